// File: rtl/stfq_rank_enq.sv
// Start-Time Fair Queueing enqueue front-end for the register-based PIFO.
// Stamps each descriptor with max(vtime, last_finish[flow]) and feeds the PIFO one entry at a time.
module stfq_rank_enq #(
  parameter int L2_MAX_SIZE  = 3,
  parameter int MAX_SIZE     = 2**L2_MAX_SIZE,
  parameter int RANK_WIDTH   = 8,
  parameter int META_WIDTH   = 8,
  parameter int L2_NUM_FLOWS = 2,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [L2_NUM_FLOWS-1:0] in_flow,
  input  logic [LEN_WIDTH-1:0]    in_len,
  input  logic [META_WIDTH-1:0]   in_meta,
  input  logic                    deq,
  input  logic [RANK_WIDTH-1:0]   deq_rank,
  output logic                    pifo_insert,
  output logic [RANK_WIDTH-1:0]   pifo_rank,
  output logic [META_WIDTH-1:0]   pifo_meta,
  output logic [L2_MAX_SIZE:0]    occupancy,
  output logic [RANK_WIDTH-1:0]   vtime,
  output logic                    deq_err
);

  localparam int NUM_FLOWS = 2**L2_NUM_FLOWS;
  localparam int SUM_WIDTH = ((RANK_WIDTH > LEN_WIDTH) ? RANK_WIDTH : LEN_WIDTH) + 1;
  // All-ones is the PIFO's empty marker, so the largest usable rank is one below it.
  localparam logic [RANK_WIDTH-1:0] RANK_MAX = {{(RANK_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [L2_MAX_SIZE:0]  OCC_FULL = (L2_MAX_SIZE+1)'(MAX_SIZE);
  localparam logic [L2_MAX_SIZE:0]  OCC_ONE  = (L2_MAX_SIZE+1)'(1);

  typedef enum logic {EMPTY, STAGED} stage_t;

  stage_t                  r_state;
  stage_t                  w_state_nxt;
  logic [RANK_WIDTH-1:0]   r_vtime;
  logic [RANK_WIDTH-1:0]   r_last_finish [NUM_FLOWS];
  logic [L2_MAX_SIZE:0]    r_occ;
  logic                    r_deq_err;
  logic [RANK_WIDTH-1:0]   r_rank;
  logic [META_WIDTH-1:0]   r_meta;

  logic                    w_hs;
  logic                    w_deq_ok;
  logic                    w_deq_bad;
  logic                    w_idle;
  logic [RANK_WIDTH-1:0]   w_lf_sel;
  logic [RANK_WIDTH-1:0]   w_start;
  logic [SUM_WIDTH-1:0]    w_sum;
  logic [RANK_WIDTH-1:0]   w_finish;

  assign in_ready    = (r_state == EMPTY) && (r_occ < OCC_FULL);
  assign w_hs        = in_valid && in_ready;
  // A PIFO remove blocks the insert this cycle; the staged entry simply retries.
  assign pifo_insert = (r_state == STAGED) && !deq && !rst;

  assign w_deq_ok  = deq && (r_occ != '0);
  assign w_deq_bad = deq && (r_occ == '0);
  // Last entry leaving with nothing staged or arriving: restart virtual time from zero.
  assign w_idle    = w_deq_ok && (r_occ == OCC_ONE) && !w_hs && (r_state == EMPTY);

  assign w_lf_sel = r_last_finish[in_flow];
  assign w_start  = (r_vtime > w_lf_sel) ? r_vtime : w_lf_sel;
  assign w_sum    = SUM_WIDTH'(w_start) + SUM_WIDTH'(in_len);
  assign w_finish = (w_sum > SUM_WIDTH'(RANK_MAX)) ? RANK_MAX : w_sum[RANK_WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_hs) w_state_nxt = STAGED;
      STAGED:  if (!deq) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_vtime   <= '0;
      r_occ     <= '0;
      r_deq_err <= 1'b0;
      r_rank    <= '0;
      r_meta    <= '0;
      for (int unsigned i = 0; i < NUM_FLOWS; i++) r_last_finish[i] <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_hs) begin
        r_rank                 <= w_start;
        r_meta                 <= in_meta;
        r_last_finish[in_flow] <= w_finish;
      end

      case ({w_hs, w_deq_ok})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase

      if (w_deq_bad) r_deq_err <= 1'b1;

      if (w_idle) begin
        r_vtime <= '0;
        for (int unsigned i = 0; i < NUM_FLOWS; i++) r_last_finish[i] <= '0;
      end else if (w_deq_ok) begin
        r_vtime <= deq_rank;
      end
    end
  end

  assign pifo_rank = r_rank;
  assign pifo_meta = r_meta;
  assign occupancy = r_occ;
  assign vtime     = r_vtime;
  assign deq_err   = r_deq_err;

endmodule

// File: tb/tb_stfq_rank_enq.sv
// Bench for stfq_rank_enq: directed vector table, hand-written corner sequences,
// and random traffic compared against a per-packet STFQ reference model.
module tb_stfq_rank_enq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_flow;
  logic [7:0] in_len;
  logic [7:0] in_meta;
  logic       deq;
  logic [7:0] deq_rank;
  logic       pifo_insert;
  logic [7:0] pifo_rank;
  logic [7:0] pifo_meta;
  logic [3:0] occupancy;
  logic [7:0] vtime;
  logic       deq_err;

  stfq_rank_enq #(
    .L2_MAX_SIZE (3),
    .RANK_WIDTH  (8),
    .META_WIDTH  (8),
    .L2_NUM_FLOWS(2),
    .LEN_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flow    (in_flow),
    .in_len     (in_len),
    .in_meta    (in_meta),
    .deq        (deq),
    .deq_rank   (deq_rank),
    .pifo_insert(pifo_insert),
    .pifo_rank  (pifo_rank),
    .pifo_meta  (pifo_meta),
    .occupancy  (occupancy),
    .vtime      (vtime),
    .deq_err    (deq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one number per quantity, plain integer arithmetic.
  int m_vt;
  int m_lf [4];
  int m_occ;
  int m_err;
  int m_staged;
  int m_rank;
  int m_meta;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vt = 0; m_occ = 0; m_err = 0; m_staged = 0; m_rank = 0; m_meta = 0;
    foreach (m_lf[i]) m_lf[i] = 0;
  endtask

  task automatic model_check();
    chk("ready", int'(in_ready), (m_staged == 0 && m_occ < 8) ? 1 : 0);
    chk("insert", int'(pifo_insert), (m_staged == 1 && !deq) ? 1 : 0);
    chk("occupancy", int'(occupancy), m_occ);
    chk("vtime", int'(vtime), m_vt);
    chk("deq_err", int'(deq_err), m_err);
    if (m_staged == 1) begin
      chk("rank", int'(pifo_rank), m_rank);
      chk("meta", int'(pifo_meta), m_meta);
    end
  endtask

  // Advance the model by one clock using the inputs the bench is driving.
  task automatic model_step();
    int accepted, removed, start, fin, emptied;
    accepted = (in_valid && m_staged == 0 && m_occ < 8) ? 1 : 0;
    removed  = (deq && m_occ > 0) ? 1 : 0;
    emptied  = (removed == 1 && m_occ == 1 && accepted == 0 && m_staged == 0) ? 1 : 0;
    if (deq && m_occ == 0) m_err = 1;
    if (m_staged == 1 && !deq) m_staged = 0;
    if (accepted == 1) begin
      start = (m_vt > m_lf[in_flow]) ? m_vt : m_lf[in_flow];
      fin   = start + int'(in_len);
      if (fin > 254) fin = 254;
      m_rank = start;
      m_meta = int'(in_meta);
      m_lf[in_flow] = fin;
      m_staged = 1;
    end
    m_occ = m_occ + accepted - removed;
    if (removed == 1) m_vt = int'(deq_rank);
    if (emptied == 1) begin
      m_vt = 0;
      foreach (m_lf[i]) m_lf[i] = 0;
    end
  endtask

  task automatic drive(input bit v, input int f, input int l, input int m, input bit d, input int dr);
    in_valid = v;
    in_flow  = 2'(f);
    in_len   = 8'(l);
    in_meta  = 8'(m);
    deq      = d;
    deq_rank = 8'(dr);
  endtask

  // One model-checked clock cycle.
  task automatic cycle(input bit v, input int f, input int l, input int m, input bit d, input int dr);
    drive(v, f, l, m, d, dr);
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("insert_in_rst", int'(pifo_insert), 0);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit v; int f; int l; int m; bit d; int dr;
    bit e_rdy; bit e_ins; int e_rank; int e_meta; int e_occ; int e_vt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    //             v f  l   meta  d dr   rdy ins rank meta  occ vt
    tbl[0]  = '{1, 0, 10, 'hA1, 0, 0,  1, 0, 0,  0,    0, 0};
    tbl[1]  = '{1, 1, 10, 'hB2, 0, 0,  0, 1, 0,  'hA1, 1, 0};
    tbl[2]  = '{1, 1, 10, 'hB2, 0, 0,  1, 0, 0,  0,    1, 0};
    tbl[3]  = '{0, 0, 0,  0,    0, 0,  0, 1, 0,  'hB2, 2, 0};
    tbl[4]  = '{1, 0, 5,  'hC3, 0, 0,  1, 0, 0,  0,    2, 0};
    tbl[5]  = '{1, 0, 5,  'hC3, 0, 0,  0, 1, 10, 'hC3, 3, 0};
    tbl[6]  = '{1, 0, 5,  'hC4, 0, 0,  1, 0, 0,  0,    3, 0};
    tbl[7]  = '{0, 0, 0,  0,    0, 0,  0, 1, 15, 'hC4, 4, 0};
    tbl[8]  = '{0, 0, 0,  0,    1, 7,  1, 0, 0,  0,    4, 0};
    tbl[9]  = '{1, 2, 4,  'hD5, 0, 0,  1, 0, 0,  0,    3, 7};
    tbl[10] = '{1, 3, 1,  'hE6, 1, 9,  0, 0, 0,  0,    4, 7};
    tbl[11] = '{0, 0, 0,  0,    0, 0,  0, 1, 7,  'hD5, 3, 9};
    tbl[12] = '{1, 3, 1,  'hE6, 1, 12, 1, 0, 0,  0,    3, 9};
    tbl[13] = '{0, 0, 0,  0,    0, 0,  0, 1, 9,  'hE6, 3, 12};

    model_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_insert", int'(pifo_insert), 0);
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_vtime", int'(vtime), 0);
    chk("rst_rank", int'(pifo_rank), 0);
    chk("rst_meta", int'(pifo_meta), 0);
    chk("rst_err", int'(deq_err), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].m, tbl[i].d, tbl[i].dr);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_insert", i), int'(pifo_insert), int'(tbl[i].e_ins));
      chk($sformatf("tbl%0d_occ", i), int'(occupancy), tbl[i].e_occ);
      chk($sformatf("tbl%0d_vtime", i), int'(vtime), tbl[i].e_vt);
      if (tbl[i].e_ins) begin
        chk($sformatf("tbl%0d_rank", i), int'(pifo_rank), tbl[i].e_rank);
        chk($sformatf("tbl%0d_meta", i), int'(pifo_meta), tbl[i].e_meta);
      end
      @(posedge clk);
      model_step();
      #1;
    end

    // Fill to capacity, free one slot, new flow starts at the dequeued rank.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1, i % 2, 1, 16 + i, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
    end
    chk("full_occ", int'(occupancy), 8);
    chk("full_ready", int'(in_ready), 0);
    cycle(0, 0, 0, 0, 1, 3);
    chk("after_deq_ready", int'(in_ready), 1);
    chk("after_deq_vtime", int'(vtime), 3);
    cycle(1, 2, 4, 'h55, 0, 0);
    chk("flow2_rank", int'(pifo_rank), 3);
    chk("flow2_meta", int'(pifo_meta), 'h55);
    cycle(0, 0, 0, 0, 0, 0);

    // Staged entry held off by three consecutive removes.
    cycle(0, 0, 0, 0, 1, 3);
    cycle(1, 3, 2, 'h66, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1, 3);
      chk("held_insert", int'(pifo_insert), 0);
      chk("held_occ", int'(occupancy), 7 - i);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("retry_insert", int'(pifo_insert), 1);
    chk("retry_rank", int'(pifo_rank), 3);
    chk("retry_meta", int'(pifo_meta), 'h66);
    @(posedge clk);
    model_step();
    #1;
    chk("retry_done", int'(pifo_insert), 0);

    // Drain to empty: virtual time and finish tags restart from zero.
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 3);
    chk("drain_occ", int'(occupancy), 0);
    chk("drain_vtime", int'(vtime), 0);
    cycle(1, 0, 7, 'h12, 0, 0);
    chk("post_idle_rank", int'(pifo_rank), 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 40);
    chk("err_clear", int'(deq_err), 0);
    cycle(0, 0, 0, 0, 1, 40);
    chk("err_set", int'(deq_err), 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    chk("err_sticky", int'(deq_err), 1);
    do_reset();
    chk("err_rst", int'(deq_err), 0);

    // Saturation at RANK_MAX, never the all-ones marker.
    cycle(1, 0, 200, 1, 0, 0);
    chk("sat_rank0", int'(pifo_rank), 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 200, 2, 0, 0);
    chk("sat_rank1", int'(pifo_rank), 200);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 200, 3, 0, 0);
    chk("sat_rank2", int'(pifo_rank), 254);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 4, 0, 0);
    chk("sat_rank3", int'(pifo_rank), 254);
    cycle(0, 0, 0, 0, 0, 0);

    // Reset while an entry is staged.
    cycle(1, 1, 5, 'h77, 0, 0);
    do_reset();
    chk("rst_staged_insert", int'(pifo_insert), 0);
    chk("rst_staged_occ", int'(occupancy), 0);
    chk("rst_staged_ready", int'(in_ready), 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit v, d;
      v = ($urandom_range(0, 99) < 60);
      d = (m_occ > 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 2);
      cycle(v, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
            d, $urandom_range(0, 254));
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
